// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_CNT0,
    S_CNT1,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         BYTES_PER_WORD    = 4;

endpackage

// File: rtl/prog_word_assembler.sv
// Packs incoming bytes LSB-first into 32-bit words and flags the 4th byte.
module prog_word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [23:0] shreg;
  logic [1:0]  byte_cnt;

  // The full word includes the byte being accepted this cycle, so it is valid with word_ready.
  assign word       = {byte_in, shreg};
  assign word_ready = byte_valid && (byte_cnt == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (byte_valid) begin
      shreg    <= word[31:8];
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream boot loader: writes words to program memory from address 0
// and releases the core reset once the frame checksum verifies.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter int         DEPTH     = 1024,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  state_t state, next_state;

  logic        xfer;
  logic        is_sync;
  logic [15:0] cnt;
  logic [15:0] cnt_in;
  logic [15:0] word_idx;
  logic [7:0]  csum;
  logic        oversize;
  logic        last_word;
  logic        byte_valid;
  logic        word_ready;
  logic [31:0] word;

  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;
  logic              cpu_rst_n_d;
  logic              done_d;
  logic              error_d;

  assign xfer       = in_valid && in_ready;
  assign is_sync    = (in_data == SYNC_BYTE);
  assign cnt_in     = {in_data, cnt[7:0]};
  assign oversize   = {1'b0, cnt_in} > 17'(DEPTH);
  assign last_word  = (word_idx + 16'd1) == cnt;
  assign byte_valid = xfer && (state == S_DATA);

  prog_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (state != S_DATA),
    .byte_valid (byte_valid),
    .byte_in    (in_data),
    .word       (word),
    .word_ready (word_ready)
  );

  // Only the memory-write cycle stalls the byte source.
  always_comb begin
    in_ready = (state != S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_SYNC;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= next_state;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      cpu_rst_n <= cpu_rst_n_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_SYNC, S_DONE, S_ERR: if (xfer && is_sync) next_state = S_CNT0;
      S_CNT0:                if (xfer) next_state = S_CNT1;
      S_CNT1: begin
        if (xfer) begin
          if (oversize)          next_state = S_ERR;
          else if (cnt_in == '0) next_state = S_CSUM;
          else                   next_state = S_DATA;
        end
      end
      S_DATA:  if (word_ready) next_state = S_WRITE;
      S_WRITE: next_state = last_word ? S_CSUM : S_DATA;
      S_CSUM:  if (xfer) next_state = (in_data == csum) ? S_DONE : S_ERR;
      default: next_state = S_SYNC;
    endcase
  end

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    mem_we_d    = (next_state == S_WRITE);
    mem_addr_d  = (next_state == S_WRITE) ? word_idx[ADDR_W-1:0] : mem_addr;
    mem_wdata_d = word_ready ? word : mem_wdata;
    done_d      = (next_state == S_DONE);
    error_d     = (next_state == S_ERR);
    cpu_rst_n_d = (next_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      word_idx <= '0;
      csum     <= '0;
    end else begin
      case (state)
        S_SYNC, S_DONE, S_ERR: if (xfer && is_sync) word_idx <= '0;
        S_CNT0: begin
          if (xfer) begin
            cnt  <= {8'h00, in_data};
            csum <= in_data;
          end
        end
        S_CNT1: begin
          if (xfer) begin
            cnt  <= cnt_in;
            csum <= csum ^ in_data;
          end
        end
        S_DATA:  if (xfer) csum <= csum ^ in_data;
        S_WRITE: word_idx <= word_idx + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
